// File: rtl/axi_rr_arbiter.sv
// Round-robin valid/ready arbiter that merges NumIn channels onto one stream, holding a stalled beat stable.
// Optional flush port and logic are enabled by defining AXI_RR_ARB_FLUSH_EN.
module axi_rr_arbiter #(
  parameter int unsigned NumIn = 4,
  parameter type         T     = logic,
  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef AXI_RR_ARB_FLUSH_EN
  input  logic                 flush_i,
`endif
  input  logic [NumIn-1:0]     req_i,
  output logic [NumIn-1:0]     gnt_o,
  input  T     [NumIn-1:0]     data_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output T                     data_o,
  output logic [IdxW-1:0]      idx_o
);

  logic [IdxW-1:0] rr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] rr_next;
  logic            flush;

`ifdef AXI_RR_ARB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // First requester found scanning upward from ptr, wrapping at NumIn (not at 2**IdxW).
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumIn-1:0] req,
                                              input logic [IdxW-1:0]  ptr);
    logic            found;
    int              j;
    logic [IdxW-1:0] jj;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(NumIn); k++) begin
      j = int'(ptr) + k;
      if (j >= int'(NumIn)) j = j - int'(NumIn);
      jj = IdxW'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        rr_pick = jj;
      end
    end
  endfunction

  always_comb begin
    sel_idx = rr_pick(req_i, rr_q);
    req_o   = |req_i;
    // A stalled beat stays pinned to its source until it handshakes or is withdrawn.
    if (lock_q) begin
      sel_idx = lock_idx_q;
      req_o   = req_i[lock_idx_q];
    end
    idx_o  = req_o ? sel_idx : '0;
    data_o = req_o ? data_i[idx_o] : '0;
  end

  for (genvar g = 0; g < int'(NumIn); g++) begin : g_gnt
    assign gnt_o[g] = gnt_i & req_o & (idx_o == IdxW'(g));
  end

  assign rr_next = (idx_o == IdxW'(NumIn - 1)) ? '0 : idx_o + IdxW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
    end else if (req_o && gnt_i) begin
      rr_q   <= rr_next;
      lock_q <= 1'b0;
    end else if (req_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= idx_o;
    end else begin
      // Nothing offered, or the locked source withdrew its request.
      lock_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench for axi_rr_arbiter: a 4-input and a 3-input instance driven with directed vectors.
module tb_axi_rr_arbiter;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
    logic [3:0] gnt;
  } exp4_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
    logic [2:0] gnt;
  } exp3_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]      req4 = '0;
  logic            gnt4 = 1'b0;
  logic [3:0][7:0] data4;
  logic [3:0]      gnt4_o;
  logic            req4_o;
  logic [7:0]      data4_o;
  logic [1:0]      idx4_o;

  logic [2:0]      req3 = '0;
  logic            gnt3 = 1'b0;
  logic [2:0][7:0] data3;
  logic [2:0]      gnt3_o;
  logic            req3_o;
  logic [7:0]      data3_o;
  logic [1:0]      idx3_o;

`ifdef AXI_RR_ARB_FLUSH_EN
  logic flush = 1'b0;
`endif

  exp4_t q4[$];
  exp3_t q3[$];
  exp4_t e4;
  exp3_t e3;
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  always #5 clk = ~clk;

  axi_rr_arbiter #(.NumIn(4), .T(logic [7:0])) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef AXI_RR_ARB_FLUSH_EN
    .flush_i(flush),
`endif
    .req_i  (req4),
    .gnt_o  (gnt4_o),
    .data_i (data4),
    .req_o  (req4_o),
    .gnt_i  (gnt4),
    .data_o (data4_o),
    .idx_o  (idx4_o)
  );

  axi_rr_arbiter #(.NumIn(3), .T(logic [7:0])) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
`ifdef AXI_RR_ARB_FLUSH_EN
    .flush_i(1'b0),
`endif
    .req_i  (req3),
    .gnt_o  (gnt3_o),
    .data_i (data3),
    .req_o  (req3_o),
    .gnt_i  (gnt3),
    .data_o (data3_o),
    .idx_o  (idx3_o)
  );

  // One cycle on the 4-input instance; the expected beat is queued when a valid output is expected.
  task automatic step4(input logic rst, input logic [3:0] req, input logic gnt,
                       input logic exp_req, input int exp_idx);
    exp4_t e;
    rst_n = rst;
    req4  = req;
    gnt4  = gnt;
    if (exp_req) begin
      e.idx  = 2'(exp_idx);
      e.data = 8'hA0 + 8'(exp_idx);
      e.gnt  = gnt ? 4'(1 << exp_idx) : 4'b0000;
      q4.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic [2:0] req, input logic gnt,
                       input logic exp_req, input int exp_idx);
    exp3_t e;
    req3 = req;
    gnt3 = gnt;
    if (exp_req) begin
      e.idx  = 2'(exp_idx);
      e.data = 8'hB0 + 8'(exp_idx);
      e.gnt  = gnt ? 3'(1 << exp_idx) : 3'b000;
      q3.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented beat against the scoreboard, and idle outputs against zero.
  always @(negedge clk) begin
    if (req4_o) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL arb4_unexpected_beat got idx=%0d data=%h gnt=%b, expected no beat",
                 idx4_o, data4_o, gnt4_o);
      end else begin
        e4 = q4.pop_front();
        if (idx4_o !== e4.idx || data4_o !== e4.data || gnt4_o !== e4.gnt) begin
          errors++;
          $display("FAIL arb4_beat t=%0t got idx=%0d data=%h gnt=%b, expected idx=%0d data=%h gnt=%b",
                   $time, idx4_o, data4_o, gnt4_o, e4.idx, e4.data, e4.gnt);
        end
      end
    end else begin
      checks++;
      if (idx4_o !== 2'd0 || data4_o !== 8'h00 || gnt4_o !== 4'b0000) begin
        errors++;
        $display("FAIL arb4_idle t=%0t got idx=%0d data=%h gnt=%b, expected 0/00/0000",
                 $time, idx4_o, data4_o, gnt4_o);
      end
    end
    if (req3_o) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL arb3_unexpected_beat got idx=%0d data=%h gnt=%b, expected no beat",
                 idx3_o, data3_o, gnt3_o);
      end else begin
        e3 = q3.pop_front();
        if (idx3_o !== e3.idx || data3_o !== e3.data || gnt3_o !== e3.gnt) begin
          errors++;
          $display("FAIL arb3_beat t=%0t got idx=%0d data=%h gnt=%b, expected idx=%0d data=%h gnt=%b",
                   $time, idx3_o, data3_o, gnt3_o, e3.idx, e3.data, e3.gnt);
        end
      end
    end else begin
      checks++;
      if (idx3_o !== 2'd0 || data3_o !== 8'h00 || gnt3_o !== 3'b000) begin
        errors++;
        $display("FAIL arb3_idle t=%0t got idx=%0d data=%h gnt=%b, expected 0/00/000",
                 $time, idx3_o, data3_o, gnt3_o);
      end
    end
    if (done) begin
      checks++;
      if (q4.size() != 0 || q3.size() != 0) begin
        errors++;
        $display("FAIL beats_missing got pending4=%0d pending3=%0d, expected 0/0", q4.size(), q3.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) data4[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 3; i++) data3[i] = 8'hB0 + 8'(i);
    repeat (2) @(posedge clk);
    #1;
    // idle after reset
    step4(1, 4'b0000, 1, 0, 0);
    step4(1, 4'b0000, 1, 0, 0);
    // all requesting, always ready: 0,1,2,3,0
    step4(1, 4'b1111, 1, 1, 0);
    step4(1, 4'b1111, 1, 1, 1);
    step4(1, 4'b1111, 1, 1, 2);
    step4(1, 4'b1111, 1, 1, 3);
    step4(1, 4'b1111, 1, 1, 0);
    // sparse requests 1010 starting from rr=1: 1,3,1,3
    step4(1, 4'b1010, 1, 1, 1);
    step4(1, 4'b1010, 1, 1, 3);
    step4(1, 4'b1010, 1, 1, 1);
    step4(1, 4'b1010, 1, 1, 3);
    // stall on input 0 while input 2 arrives; held until accepted
    step4(1, 4'b0001, 0, 1, 0);
    step4(1, 4'b0101, 0, 1, 0);
    step4(1, 4'b0101, 0, 1, 0);
    step4(1, 4'b0101, 1, 1, 0);
    step4(1, 4'b0101, 1, 1, 2);
    // rr=3: lock on 2 ignores input 3, then withdrawal releases the lock
    step4(1, 4'b0100, 0, 1, 2);
    step4(1, 4'b1100, 0, 1, 2);
    step4(1, 4'b1000, 1, 0, 0);
    step4(1, 4'b1000, 1, 1, 3);
    // reset while locked on 2 re-arbitrates from input 0
    step4(1, 4'b0100, 0, 1, 2);
    step4(1, 4'b1111, 0, 1, 2);
    step4(0, 4'b1111, 0, 1, 0);
    step4(1, 4'b1111, 1, 1, 0);
    step4(1, 4'b1111, 1, 1, 1);
`ifdef AXI_RR_ARB_FLUSH_EN
    // rr=2, lock on 2, flush releases lock and resets pointer
    step4(1, 4'b1111, 0, 1, 2);
    flush = 1'b1;
    step4(1, 4'b1111, 0, 1, 2);
    flush = 1'b0;
    step4(1, 4'b1111, 1, 1, 0);
`endif
    step4(1, 4'b0000, 0, 0, 0);
    // three inputs: pointer wraps 2 -> 0
    step3(3'b111, 1, 1, 0);
    step3(3'b111, 1, 1, 1);
    step3(3'b111, 1, 1, 2);
    step3(3'b111, 1, 1, 0);
    step3(3'b111, 1, 1, 1);
    step3(3'b100, 1, 1, 2);
    step3(3'b011, 1, 1, 0);
    step3(3'b000, 0, 0, 0);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL bench_end got no summary from monitor, expected summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
